// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// IF queries it combinationally; ID resolves beq and sends updates and statistics.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            lookup_valid_i,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            pred_hit_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            update_valid_i,
  input  logic [XLEN-1:0] update_pc_i,
  input  logic            update_taken_i,
  input  logic [XLEN-1:0] update_target_i,
  input  logic            update_mispredict_i,
  input  logic            flush_i,
  output logic [CNT_W-1:0] branch_count_o,
  output logic [CNT_W-1:0] mispredict_count_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [XLEN-1:0]    target_d [ENTRIES];
  logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]   mispredict_cnt_q, mispredict_cnt_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;

  // Low two PC bits never address the table (instructions are word aligned).
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lookup_pc_i[1:0], update_pc_i[1:0]};

  assign lk_idx = lookup_pc_i[IDX_W+1:2];
  assign lk_tag = lookup_pc_i[XLEN-1:IDX_W+2];
  assign up_idx = update_pc_i[IDX_W+1:2];
  assign up_tag = update_pc_i[XLEN-1:IDX_W+2];

  // Uninitialised tags/targets stay masked because every use is gated by valid.
  assign pred_hit_o    = lookup_valid_i & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign pred_taken_o  = pred_hit_o & ctr_q[lk_idx][1];
  assign pred_target_o = pred_taken_o ? target_q[lk_idx] : lookup_pc_i + PC_STEP;

  assign up_hit = valid_q[up_idx] & (tag_q[up_idx] == up_tag);

  assign branch_count_o     = branch_cnt_q;
  assign mispredict_count_o = mispredict_cnt_q;

  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves it unassigned (no latches).
    valid_d          = valid_q;
    ctr_d            = ctr_q;
    tag_d            = tag_q;
    target_d         = target_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;

    if (flush_i) begin
      valid_d = '0;
    end else if (update_valid_i) begin
      if (up_hit) begin
        if (update_taken_i) begin
          if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
          target_d[up_idx] = update_target_i;
        end else if (ctr_q[up_idx] != 2'b00) begin
          ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
        end
      end else if (update_taken_i) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = update_target_i;
        ctr_d[up_idx]    = 2'b10;
      end
    end

    // Statistics see every resolved branch, including one discarded by a flush.
    if (update_valid_i) begin
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (update_mispredict_i && (mispredict_cnt_q != '1))
        mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments; combinational logic above uses blocking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q          <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b00;
    end else begin
      valid_q          <= valid_d;
      ctr_q            <= ctr_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  // NOTE: tag/target arrays carry no reset; a cleared valid bit hides their contents.
  always_ff @(posedge clk_i) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expectations are queued as stimulus is
// driven and compared against the DUT on the falling edge of the same cycle.
module tb_branch_predictor;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             lookup_valid_i;
  logic [XLEN-1:0]  lookup_pc_i;
  logic             pred_hit_o;
  logic             pred_taken_o;
  logic [XLEN-1:0]  pred_target_o;
  logic             update_valid_i;
  logic [XLEN-1:0]  update_pc_i;
  logic             update_taken_i;
  logic [XLEN-1:0]  update_target_i;
  logic             update_mispredict_i;
  logic             flush_i;
  logic [CNT_W-1:0] branch_count_o;
  logic [CNT_W-1:0] mispredict_count_o;

  always #5 clk_i = ~clk_i;

  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .lookup_valid_i      (lookup_valid_i),
    .lookup_pc_i         (lookup_pc_i),
    .pred_hit_o          (pred_hit_o),
    .pred_taken_o        (pred_taken_o),
    .pred_target_o       (pred_target_o),
    .update_valid_i      (update_valid_i),
    .update_pc_i         (update_pc_i),
    .update_taken_i      (update_taken_i),
    .update_target_i     (update_target_i),
    .update_mispredict_i (update_mispredict_i),
    .flush_i             (flush_i),
    .branch_count_o      (branch_count_o),
    .mispredict_count_o  (mispredict_count_o)
  );

  typedef enum int {S_HIT, S_TAKEN, S_TARGET, S_BCNT, S_MCNT} sig_e;
  typedef struct {
    string           tag;
    sig_e            sig;
    logic [XLEN-1:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input sig_e sig, input logic [XLEN-1:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic exp_lookup(input string tag, input logic hit, input logic taken,
                            input logic [XLEN-1:0] tgt);
    push({tag, "_hit"},    S_HIT,    XLEN'(hit));
    push({tag, "_taken"},  S_TAKEN,  XLEN'(taken));
    push({tag, "_target"}, S_TARGET, tgt);
  endtask

  task automatic exp_cnt(input string tag, input int bc, input int mc);
    push({tag, "_bcnt"}, S_BCNT, XLEN'(bc));
    push({tag, "_mcnt"}, S_MCNT, XLEN'(mc));
  endtask

  // Monitor: drains everything queued for this cycle, mid-cycle.
  always @(negedge clk_i) begin
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sig)
        S_HIT:    check(e.tag, XLEN'(pred_hit_o),         e.val);
        S_TAKEN:  check(e.tag, XLEN'(pred_taken_o),       e.val);
        S_TARGET: check(e.tag, pred_target_o,             e.val);
        S_BCNT:   check(e.tag, XLEN'(branch_count_o),     e.val);
        default:  check(e.tag, XLEN'(mispredict_count_o), e.val);
      endcase
    end
  end

  task automatic clr();
    rst_i               = 1'b0;
    lookup_valid_i      = 1'b0;
    lookup_pc_i         = '0;
    update_valid_i      = 1'b0;
    update_pc_i         = '0;
    update_taken_i      = 1'b0;
    update_target_i     = '0;
    update_mispredict_i = 1'b0;
    flush_i             = 1'b0;
  endtask

  task automatic lk(input logic [XLEN-1:0] pc);
    lookup_valid_i = 1'b1;
    lookup_pc_i    = pc;
  endtask

  task automatic up(input logic [XLEN-1:0] pc, input logic taken,
                    input logic [XLEN-1:0] tgt, input logic mis);
    update_valid_i      = 1'b1;
    update_pc_i         = pc;
    update_taken_i      = taken;
    update_target_i     = tgt;
    update_mispredict_i = mis;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    clr();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b1;
    tick();

    lk(32'h40); exp_lookup("rst_lk", 0, 0, 32'h44); exp_cnt("rst", 0, 0); tick();

    lk(32'h40); up(32'h40, 1, 32'h20, 1);
    exp_lookup("first_upd_same_cyc", 0, 0, 32'h44); tick();
    lk(32'h40); exp_lookup("alloc", 1, 1, 32'h20); exp_cnt("alloc", 1, 1); tick();

    lk(32'h40); up(32'h40, 0, 32'h0, 1);  exp_lookup("hyst_10", 1, 1, 32'h20);  tick();
    lk(32'h40); up(32'h40, 0, 32'h0, 0);  exp_lookup("hyst_01", 1, 0, 32'h44);  tick();
    lk(32'h40); up(32'h40, 1, 32'h20, 0); exp_lookup("hyst_00", 1, 0, 32'h44);
    exp_cnt("hyst", 3, 2); tick();
    lk(32'h40); up(32'h40, 1, 32'h20, 0); exp_lookup("hyst_01b", 1, 0, 32'h44); tick();
    lk(32'h40); up(32'h40, 1, 32'h20, 0); exp_lookup("hyst_10b", 1, 1, 32'h20); tick();
    up(32'h40, 1, 32'h20, 0); tick();
    lk(32'h40); up(32'h40, 0, 32'h0, 0);  exp_lookup("ctr_sat_11", 1, 1, 32'h20); tick();
    lk(32'h40); exp_lookup("ctr_dec_10", 1, 1, 32'h20); exp_cnt("ctr", 8, 2); tick();

    up(32'h40, 1, 32'h24, 0); tick();
    lk(32'h40); exp_lookup("hit_tgt_rewrite", 1, 1, 32'h24); tick();

    lk(32'h80); up(32'h80, 1, 32'h100, 1); exp_lookup("alias_miss", 0, 0, 32'h84); tick();
    lk(32'h80); exp_lookup("alias_repl", 1, 1, 32'h100); tick();
    lk(32'h40); exp_lookup("alias_evict", 0, 0, 32'h44); exp_cnt("alias", 10, 3); tick();

    up(32'h44, 1, 32'h200, 0); tick();
    lk(32'h44); up(32'h48, 0, 32'h0, 0); exp_lookup("idx1_hit", 1, 1, 32'h200); tick();
    lk(32'h48); exp_lookup("nt_no_alloc", 0, 0, 32'h4c); tick();
    lookup_pc_i = 32'h44; exp_lookup("lookup_off", 0, 0, 32'h48); tick();

    flush_i = 1'b1; up(32'h4c, 1, 32'h300, 0); lk(32'h80);
    exp_lookup("flush_same_cyc", 1, 1, 32'h100); tick();
    lk(32'h80); exp_lookup("flush_80", 0, 0, 32'h84); exp_cnt("flush", 13, 3); tick();
    lk(32'h44); exp_lookup("flush_44", 0, 0, 32'h48); tick();
    lk(32'h4c); exp_lookup("flush_drop_upd", 0, 0, 32'h50); tick();
    up(32'h80, 1, 32'h100, 0); tick();
    lk(32'h80); exp_lookup("realloc", 1, 1, 32'h100); tick();

    rst_i = 1'b1; up(32'h40, 1, 32'h20, 1); tick();
    lk(32'h80); exp_lookup("rst_mid_80", 0, 0, 32'h84); exp_cnt("rst_mid", 0, 0); tick();
    lk(32'h40); exp_lookup("rst_drop_upd", 0, 0, 32'h44); tick();
    update_mispredict_i = 1'b1; tick();
    exp_cnt("mis_no_valid", 0, 0); tick();

    for (int i = 0; i < 14; i++) begin
      up(32'h1000 + 32'(4 * i), 1, 32'h2000, 1);
      tick();
    end
    exp_cnt("stat_14", 14, 14); tick();
    for (int i = 0; i < 6; i++) begin
      up(32'h1000 + 32'(4 * i), 1, 32'h2000, 1);
      tick();
    end
    exp_cnt("stat_sat", 15, 15); tick();

    for (int i = 0; i < 4 && sb_q.size() > 0; i++) tick();
    check("sb_drain", XLEN'(sb_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised branch prediction unit for the 5-stage pipelined CPU. It replaces the fixed "predict not-taken, flush on taken" scheme with a direct-mapped branch target buffer that has 2-bit saturating counters. The IF stage queries it each cycle with the fetch PC. The ID stage, where beq is resolved, sends update and statistics traffic back to it.

Parameters:
XLEN, 32, PC/target width in bits.
ENTRIES, 16, BTB entry count; power of 2, minimum 2.
IDX_W, $clog2(ENTRIES), index width; derived, not overridden.
CNT_W, 32, width of the statistics counters.

Ports:
clk_i  in  1  clock; all state changes on its rising edge.
rst_i  in  1  reset, synchronous, active-high.
lookup_valid_i  in  1  IF-stage lookup enable.
lookup_pc_i  in  XLEN  fetch PC.
pred_hit_o  out  1  valid BTB entry matches lookup_pc_i.
pred_taken_o  out  1  predict taken.
pred_target_o  out  XLEN  next-PC prediction.
update_valid_i  in  1  a resolved branch is present in ID this cycle.
update_pc_i  in  XLEN  PC of the resolved branch.
update_taken_i  in  1  actual outcome.
update_target_i  in  XLEN  actual taken target (PC + imm<<1).
update_mispredict_i  in  1  the IF prediction for this branch was wrong.
flush_i  in  1  invalidate all BTB entries.
branch_count_o  out  CNT_W  resolved-branch count.
mispredict_count_o  out  CNT_W  mispredict count.

Behaviour:
- Address split:
  - index = pc[IDX_W+1:2]
  - tag = pc[XLEN-1:IDX_W+2]
  - pc[1:0] ignored
- Entry contents: valid, tag, target[XLEN], ctr[1:0].
- Lookup is combinational from registered table state; zero latency.
  - hit = lookup_valid_i & valid[idx] & (tag[idx] == lookup tag).
  - pred_taken_o = hit & ctr[idx][1].
  - pred_target_o = target[idx] when pred_taken_o, otherwise lookup_pc_i + 4 (modulo 2^XLEN).
  - When lookup_valid_i = 0: hit = 0, taken = 0, target = lookup_pc_i + 4.
- Update is registered and takes effect at the next rising edge, only when update_valid_i = 1.
  - Hit at update index: ctr increments (saturate at 11) if taken, decrements (saturate at 00) if not taken. If taken, target is overwritten with update_target_i. Tag and valid are unchanged.
  - Miss and taken: allocate or replace the entry. valid = 1, tag written, target = update_target_i, ctr = 10 (weakly taken).
  - Miss and not taken: no table write.
- No write-to-read bypass: a lookup in the same cycle as an update to the same entry sees the pre-update state. The new state is visible the following cycle.
- Statistics counters:
  - branch_count_o increments on each update_valid_i.
  - mispredict_count_o increments when update_valid_i & update_mispredict_i.
  - Both saturate at 2^CNT_W - 1 (no wrap).
  - update_mispredict_i is ignored when update_valid_i = 0.
- flush_i: all valid bits are cleared at the next edge. Tags, targets, ctrs and statistics are retained. An update in the same cycle as flush_i is discarded; flush wins. Statistics still count that update.
- Priority order: rst_i > flush_i > update.
- Reset (sync, rst_i high at the edge):
  - All valid bits = 0, all ctr = 00, both stats counters = 0. Tags and targets need no reset.
  - An update presented in the reset cycle has no effect.
  - Reset mid-stream leaves the table empty the following cycle.
- Output values after reset: pred_hit_o = 0, pred_taken_o = 0, pred_target_o = lookup_pc_i + 4, counters = 0.
- No X may propagate to outputs from uninitialised tags or targets. Gating by valid is mandatory.

Test Plan:
1. Reset, then lookup_pc 0x40 -> hit 0, taken 0, target 0x44; both counters 0.
2. Update pc 0x40, taken, target 0x20 -> next cycle lookup 0x40 gives hit 1, taken 1, target 0x20; branch_count 1.
3. Hysteresis on 0x40 (ctr 10):
   - Not-taken twice -> ctr 00; lookup gives hit 1, taken 0, target 0x44.
   - Taken once -> ctr 01, still not taken.
   - Taken again -> ctr 10, taken, target 0x20.
4. Alias (ENTRIES = 16): 0x40 allocated; lookup 0x80 (same index 0, different tag) -> miss. Taken update 0x80 -> target 0x100 replaces the entry; lookup 0x40 now misses.
5. Same-cycle cases:
   - Lookup 0x40 in the cycle of its first taken update -> miss; next cycle -> hit.
   - rst_i with update_valid_i -> table empty, counters 0.
   - flush_i with update -> all lookups miss; branch_count still increments.
6. Saturation with CNT_W = 4: 20 updates with mispredict = 1 -> both counters hold 15.
